// File: rtl/disp_host_writer.sv
// Host-side writer for the display adaptor: fills two ping-pong video buffers from
// a valid/ready pixel stream and marks a buffer full once a whole frame has landed.
module disp_host_writer #(
    parameter int PIX_PER_LINE = 10,
    parameter int LINES        = 10,
    parameter int DATA_W       = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              CSHost,
    input  logic              HostValid,
    input  logic [DATA_W-1:0] HostData,
    output logic              HostReady,
    input  logic [1:0]        BufRelease,
    output logic [1:0]        BufFull,
    output logic              WEOut,
    output logic              WSel,
    output logic [3:0]        WAddrL,
    output logic [3:0]        WAddrP,
    output logic [DATA_W-1:0] WData,
    output logic              FrameDone
);
    localparam logic [3:0] PIX_LAST  = 4'(PIX_PER_LINE - 1);
    localparam logic [3:0] LINE_LAST = 4'(LINES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUF, WRITE, COMMIT} state_t;

    state_t            state_q, state_d;
    logic              wptr_q, wptr_d;
    logic [3:0]        pix_q, pix_d;
    logic [3:0]        line_q, line_d;
    logic [1:0]        full_q, full_d;
    logic              we_q, we_d;
    logic              wsel_q, wsel_d;
    logic [3:0]        addrl_q, addrl_d;
    logic [3:0]        addrp_q, addrp_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              accept;

    assign HostReady = (state_q == WRITE) && CSHost;
    assign accept    = HostReady && HostValid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= 1'b0;
            pix_q   <= '0;
            line_q  <= '0;
            full_q  <= '0;
            we_q    <= 1'b0;
            wsel_q  <= 1'b0;
            addrl_q <= '0;
            addrp_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            full_q  <= full_d;
            we_q    <= we_d;
            wsel_q  <= wsel_d;
            addrl_q <= addrl_d;
            addrp_q <= addrp_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        pix_d   = pix_q;
        line_d  = line_q;
        full_d  = full_q & ~BufRelease;
        we_d    = 1'b0;
        wsel_d  = wsel_q;
        addrl_d = addrl_q;
        addrp_d = addrp_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CSHost) state_d = WAIT_BUF;
            end
            WAIT_BUF: begin
                if (!CSHost)               state_d = IDLE;
                else if (!full_q[wptr_q])  state_d = WRITE;
            end
            WRITE: begin
                if (accept) begin
                    we_d    = 1'b1;
                    wsel_d  = wptr_q;
                    addrl_d = line_q;
                    addrp_d = pix_q;
                    wdata_d = HostData;
                    if (pix_q == PIX_LAST) begin
                        pix_d = '0;
                        if (line_q == LINE_LAST) begin
                            line_d  = '0;
                            state_d = COMMIT;
                        end else begin
                            line_d = line_q + 4'd1;
                        end
                    end else begin
                        pix_d = pix_q + 4'd1;
                    end
                end
            end
            COMMIT: begin
                // Applied after the release mask so a same-cycle release cannot clear it.
                full_d[wptr_q] = 1'b1;
                done_d  = 1'b1;
                wptr_d  = ~wptr_q;
                pix_d   = '0;
                line_d  = '0;
                state_d = CSHost ? WAIT_BUF : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign BufFull   = full_q;
    assign WEOut     = we_q;
    assign WSel      = wsel_q;
    assign WAddrL    = addrl_q;
    assign WAddrP    = addrp_q;
    assign WData     = wdata_q;
    assign FrameDone = done_q;

endmodule

// File: tb/tb_disp_host_writer.sv
// Directed bench for disp_host_writer with a 4x2 frame; expected writes, flags and
// handshake values are hand-computed per cycle.
module tb_disp_host_writer;
    logic        clock = 1'b0;
    logic        reset;
    logic        CSHost;
    logic        HostValid;
    logic [11:0] HostData;
    logic        HostReady;
    logic [1:0]  BufRelease;
    logic [1:0]  BufFull;
    logic        WEOut;
    logic        WSel;
    logic [3:0]  WAddrL;
    logic [3:0]  WAddrP;
    logic [11:0] WData;
    logic        FrameDone;

    int errs   = 0;
    int checks = 0;
    int hi;

    disp_host_writer #(.PIX_PER_LINE(4), .LINES(2), .DATA_W(12)) dut (
        .clock      (clock),
        .reset      (reset),
        .CSHost     (CSHost),
        .HostValid  (HostValid),
        .HostData   (HostData),
        .HostReady  (HostReady),
        .BufRelease (BufRelease),
        .BufFull    (BufFull),
        .WEOut      (WEOut),
        .WSel       (WSel),
        .WAddrL     (WAddrL),
        .WAddrP     (WAddrP),
        .WData      (WData),
        .FrameDone  (FrameDone)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {6'b0, HostReady, BufFull, WEOut, WSel, WAddrL, WAddrP, WData, FrameDone};
    endfunction

    task automatic clk();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input string tag, input logic sel, input logic [3:0] l,
                      input logic [3:0] p, input logic [11:0] d);
        HostData  = d;
        HostValid = 1'b1;
        clk();
        chk(tag, {WEOut, WSel, WAddrL, WAddrP, WData}, {1'b1, sel, l, p, d});
    endtask

    task automatic frame(input logic sel, input logic [11:0] base);
        for (int unsigned l = 0; l < 2; l++)
            for (int unsigned p = 0; p < 4; p++)
                wr($sformatf("frame_s%0d_%0d_%0d", sel, l, p), sel, 4'(l), 4'(p),
                   base + 12'(l * 4 + p));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; CSHost = 1'b0; HostValid = 1'b0; HostData = '0; BufRelease = '0;
        #12;
        chk("reset_outs", outs(), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // First frame into buffer 0 with HostValid held high
        CSHost = 1'b1; HostValid = 1'b1; HostData = 12'h100;
        clk();
        chk("wait_buf_rdy", HostReady, 32'd0);
        clk();
        chk("rdy_2nd_cycle", {HostReady, WEOut}, 32'b10);
        frame(1'b0, 12'h100);
        chk("commit_rdy", {HostReady, FrameDone, BufFull}, 32'b0000);
        clk();
        chk("frame1_done", {FrameDone, BufFull, WEOut}, 32'b1010);
        clk();
        chk("frame2_rdy", {FrameDone, HostReady}, 32'b01);

        // Second frame into buffer 1, then both full -> stall
        frame(1'b1, 12'h200);
        clk();
        chk("frame2_done", {FrameDone, BufFull}, 32'b111);
        hi = 0;
        repeat (22) begin
            clk();
            if (HostReady || WEOut) hi++;
        end
        chk("stall_both_full", hi, 32'd0);

        BufRelease = 2'b01;
        clk();
        BufRelease = 2'b00;
        chk("release0", {BufFull, HostReady}, 32'b100);
        clk();
        chk("release_rdy", HostReady, 32'd1);
        wr("f3_00", 1'b0, 4'd0, 4'd0, 12'h300);
        wr("f3_01", 1'b0, 4'd0, 4'd1, 12'h301);
        wr("f3_02", 1'b0, 4'd0, 4'd2, 12'h302);

        // Chip select dropped mid-frame
        CSHost = 1'b0;
        #1;
        chk("cs_drop_rdy", HostReady, 32'd0);
        hi = 0;
        repeat (5) begin
            clk();
            if (HostReady || WEOut) hi++;
        end
        chk("cs_drop_quiet", hi, 32'd0);
        CSHost = 1'b1;
        #1;
        chk("cs_resume_rdy", HostReady, 32'd1);
        wr("resume_03", 1'b0, 4'd0, 4'd3, 12'h303);

        // Alternating HostValid; stray release of the empty buffer 0
        wr("alt_a5a", 1'b0, 4'd1, 4'd0, 12'hA5A);
        HostValid = 1'b0; HostData = 12'hFFF; BufRelease = 2'b01;
        clk();
        BufRelease = 2'b00;
        chk("alt_gap1_empty_rel", {WEOut, BufFull}, 32'b010);
        wr("alt_0f0", 1'b0, 4'd1, 4'd1, 12'h0F0);
        HostValid = 1'b0; HostData = 12'hEEE;
        clk();
        chk("alt_gap2", WEOut, 32'd0);
        wr("alt_3c3", 1'b0, 4'd1, 4'd2, 12'h3C3);
        HostValid = 1'b0; HostData = 12'hDDD;
        clk();
        chk("alt_gap3", WEOut, 32'd0);
        wr("alt_5a5", 1'b0, 4'd1, 4'd3, 12'h5A5);

        // Release of buffer 0 during its own COMMIT: set wins
        BufRelease = 2'b01; HostValid = 1'b0;
        clk();
        BufRelease = 2'b00;
        chk("set_wins", {FrameDone, BufFull}, 32'b111);

        BufRelease = 2'b11;
        clk();
        BufRelease = 2'b00;
        chk("release_both", {BufFull, HostReady}, 32'b000);
        clk();
        chk("rdy_buf1", HostReady, 32'd1);
        frame(1'b1, 12'h400);
        clk();
        chk("full10", {FrameDone, BufFull}, 32'b110);
        clk();
        wr("p_00", 1'b0, 4'd0, 4'd0, 12'h500);
        wr("p_01", 1'b0, 4'd0, 4'd1, 12'h501);
        wr("p_02", 1'b0, 4'd0, 4'd2, 12'h502);
        wr("p_03", 1'b0, 4'd0, 4'd3, 12'h503);
        wr("p_10", 1'b0, 4'd1, 4'd0, 12'h504);
        wr("p_11", 1'b0, 4'd1, 4'd1, 12'h505);

        // Asynchronous reset mid-frame
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_outs", outs(), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        clk();
        chk("post_reset_wait", {HostReady, BufFull}, 32'b000);
        clk();
        wr("post_reset_00", 1'b0, 4'd0, 4'd0, 12'h600);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/disp_host_writer.md
Name: disp_host_writer

Overview:
- Host-side write controller for the display adaptor. It fills the two ping-pong video buffers that the display-side controller drains.
- It accepts pixel words from the host over a valid/ready handshake and generates buffer write strobes, buffer select, and line/pixel addresses.
- It marks a buffer full when a whole frame has been written. The display side frees the buffer by pulsing a release.
- It is the writer counterpart to the display read controller. Address widths match that controller's 4-bit line and pixel address buses.

Parameters:
- PIX_PER_LINE, 10, pixels per line (2..16).
- LINES, 10, lines per frame (1..16).
- DATA_W, 12, pixel word width (4 bits each for R, G, B).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- CSHost  in  1  host chip select; enables writing.
- HostValid  in  1  host pixel word valid.
- HostData  in  DATA_W  host pixel word.
- HostReady  out  1  writer can accept a word this cycle (combinational from state, CSHost, flags).
- BufRelease  in  2  one-cycle pulse per buffer from the display controller: buffer i consumed.
- BufFull  out  2  buffer i holds a complete unread frame.
- WEOut  out  1  buffer write strobe, registered.
- WSel  out  1  buffer targeted by WEOut.
- WAddrL  out  4  line address of the written word.
- WAddrP  out  4  pixel address of the written word.
- WData  out  DATA_W  written word.
- FrameDone  out  1  one-cycle pulse when a buffer is committed.

Behaviour:
- Reset (asynchronous): all outputs 0. The state machine goes to IDLE, the write pointer selects buffer 0, and the pixel and line counters are 0.
- States are IDLE, WAIT_BUF, WRITE, COMMIT.
- IDLE:
  - HostReady=0.
  - CSHost=1 -> WAIT_BUF.
- WAIT_BUF:
  - HostReady=0.
  - BufFull[wptr]=0 -> WRITE; otherwise hold.
  - CSHost=0 -> IDLE.
- WRITE:
  - HostReady=CSHost.
  - An accept is HostValid & HostReady at a rising edge.
  - On accept, the next cycle shows WEOut=1, WSel=wptr, WAddrL=line, WAddrP=pix, WData=HostData. WEOut is 0 in every cycle not following an accept.
  - Back-to-back accepts give one word per cycle.
  - Counters: pix increments per accept. At pix=PIX_PER_LINE-1 it wraps to 0 and line increments.
  - An accept at pix=PIX_PER_LINE-1 and line=LINES-1 -> COMMIT; that final word's WEOut appears during COMMIT.
  - CSHost=0 mid-frame: HostReady=0 and the counters hold in WRITE. Writing resumes at the same address when CSHost returns; there is no restart.
- COMMIT (one cycle):
  - HostReady=0.
  - Sets BufFull[wptr] at the end of the cycle and pulses FrameDone.
  - Toggles wptr and clears pix and line.
  - Next state: WAIT_BUF if CSHost=1, else IDLE.
- BufRelease[i] clears BufFull[i] at the next edge.
  - A release of a non-full buffer is ignored.
  - Set and release of the same buffer in the same cycle: set wins; the flag stays 1.
  - Releases are honoured in every state.
- Both buffers full: the writer stalls in WAIT_BUF with HostReady=0 until the targeted buffer is released. It then enters WRITE the cycle after the release is seen.
- Counters never exceed PIX_PER_LINE-1 or LINES-1. Addresses are zero-extended to 4 bits.
- Reset asserted mid-frame: the partial frame is discarded, both BufFull bits clear, and writing restarts at buffer 0, address 0,0.

Test Plan:
- Reset, then CSHost=1 with HostValid held high and PIX_PER_LINE=4, LINES=2 -> HostReady=1 from the 2nd cycle. WEOut follows on 8 consecutive cycles with (L,P) = 0,0 0,1 0,2 0,3 1,0 1,1 1,2 1,3 and WSel=0. FrameDone pulses once, then BufFull=01.
- Continue streaming -> the second frame is written to WSel=1 and BufFull=11. The writer then stalls with HostReady=0 for over 20 cycles. A BufRelease=01 pulse -> HostReady rises 2 cycles later and writes target buffer 0 at address 0,0.
- Drop CSHost after the 3rd word (address 0,2) for 5 cycles -> no WEOut and HostReady=0. On resume, the next WEOut carries address 0,3.
- Deassert HostValid on alternate cycles with HostData=12'hA5A, 12'h0F0, ... -> WEOut only follows accepted cycles, and WData matches the accepted word.
- Assert BufRelease[0] in the same cycle that COMMIT sets BufFull[0] -> BufFull[0]=1 afterwards. A release of an empty buffer causes no change.
- Assert reset mid-frame at address 1,1 with BufFull=10 -> all outputs 0 immediately (asynchronously). The next frame starts at buffer 0, address 0,0.
